// File: rtl/seg_argmax_stream.sv
// Streaming per-pixel argmax: NUM_CLASSES signed logit beats in, one 8-bit label out, 1-cycle latency.
// Optional SEG_ARGMAX_SCORE_OUT_EN adds out_score (winning logit, aligned with out_label).
module seg_argmax_stream #(
  parameter int INPUT_WIDTH  = 224,
  parameter int INPUT_HEIGHT = 224,
  parameter int NUM_CLASSES  = 21,
  parameter int SCORE_W      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [SCORE_W-1:0] in_score,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [7:0]                out_label,
  output logic                      out_last,
  output logic                      busy,
  output logic                      frame_done
`ifdef SEG_ARGMAX_SCORE_OUT_EN
  ,
  output logic signed [SCORE_W-1:0] out_score
`endif
);

  localparam logic [7:0]  LAST_CLS = 8'(NUM_CLASSES - 1);
  localparam logic [31:0] LAST_PIX = 32'(INPUT_WIDTH * INPUT_HEIGHT - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, next_state;

  logic [7:0]                class_cnt;
  logic [31:0]               pix_cnt;
  logic signed [SCORE_W-1:0] run_max;
  logic [7:0]                run_idx;
  logic                      final_label_pending;

  logic                      accept;
  logic                      last_beat;
  logic                      last_pix;
  logic                      final_hs;
  logic signed [SCORE_W-1:0] cand_max;
  logic [7:0]                cand_idx;

  assign in_ready  = (state == RUN) && (!out_valid || out_ready) && !final_label_pending;
  assign accept    = in_valid && in_ready;
  assign last_beat = (class_cnt == LAST_CLS);
  assign last_pix  = (pix_cnt == LAST_PIX);
  assign final_hs  = (state == RUN) && out_valid && out_ready && out_last;
  assign busy      = (state == RUN);

  // The current beat is folded in so the last beat's label can register without an extra cycle.
  always_comb begin
    cand_max = run_max;
    cand_idx = run_idx;
    if ((class_cnt == 8'd0) || (in_score > run_max)) begin
      cand_max = in_score;
      cand_idx = class_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (final_hs) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      class_cnt           <= 8'd0;
      pix_cnt             <= 32'd0;
      run_max             <= '0;
      run_idx             <= 8'd0;
      final_label_pending <= 1'b0;
      out_valid           <= 1'b0;
      out_label           <= 8'd0;
      out_last            <= 1'b0;
      frame_done          <= 1'b0;
`ifdef SEG_ARGMAX_SCORE_OUT_EN
      out_score           <= '0;
`endif
    end else begin
      frame_done <= final_hs;

      if (state == IDLE) begin
        final_label_pending <= 1'b0;
        if (start) begin
          class_cnt <= 8'd0;
          pix_cnt   <= 32'd0;
          run_max   <= '0;
          run_idx   <= 8'd0;
        end
      end

      if (accept) begin
        run_max <= cand_max;
        run_idx <= cand_idx;
        if (last_beat) begin
          class_cnt <= 8'd0;
          pix_cnt   <= pix_cnt + 32'd1;
          if (last_pix) final_label_pending <= 1'b1;
        end else begin
          class_cnt <= class_cnt + 8'd1;
        end
      end

      // A new label may replace the one handing off this same cycle.
      if (accept && last_beat) begin
        out_valid <= 1'b1;
        out_label <= cand_idx;
        out_last  <= last_pix;
`ifdef SEG_ARGMAX_SCORE_OUT_EN
        out_score <= cand_max;
`endif
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule
